// File: rtl/fpga_spi_cmd.sv
// fpga_spi_cmd: SPI command receiver feeding the HF mode mux.
// Oversamples spck/ncs/mosi in the pck0 domain and decodes 16-bit frames.
// Opcode 4'b0001 (SET_CONFREG) updates conf_word. A major-mode change is
// bracketed by a blanking window in which the mux must force mode 111.
// Malformed frames pulse cmd_err and are counted in err_count.
// Optional feature macro: FPGA_SPI_CMD_READBACK_EN. When defined, MISO
// shifts out {4'b0001, err_count, conf_word} MSB first.
module fpga_spi_cmd #(
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 16
) (
    input  logic       pck0,
    input  logic       reset,
    input  logic       spck,
    input  logic       ncs,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] conf_word,
    output logic       conf_valid,
    output logic       mode_blank,
    output logic       cmd_err,
    output logic [3:0] err_count
);

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);
    localparam logic [7:0] CONF_RESET = 8'hE0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BLANK_PRE  = 2'd1,
        BLANK_POST = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] spck_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   spck_d;
    logic                   ncs_d;

    logic spck_s;
    logic ncs_s;
    logic mosi_s;
    logic spck_rise;
    logic ncs_fall;
    logic ncs_rise;

    assign spck_s    = spck_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign spck_rise = spck_s & ~spck_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    // Shift the asynchronous pins through the synchronizer chains.
    // NOTE: the ncs chain resets to the idle-high level; resetting it low
    // would fake a rising edge after reset and count a bogus error frame.
    always_ff @(posedge pck0 or posedge reset) begin
        if (reset) begin
            spck_sync <= '0;
            ncs_sync  <= '1;
            mosi_sync <= '0;
            spck_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, giving a true multi-flop chain.
            spck_sync <= {spck_sync[SYNC_STAGES-2:0], spck};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            spck_d    <= spck_s;
            ncs_d     <= ncs_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame capture and decode
    // ------------------------------------------------------------------
    logic [4:0]  bit_cnt;
    logic [15:0] sr;
    logic        frame_ok;
    logic        accept;
    logic        bad_frame;
    logic [7:0]  new_word;

    assign frame_ok  = (bit_cnt == 5'd16);
    assign accept    = ncs_rise & frame_ok & (sr[15:12] == 4'b0001);
    assign bad_frame = ncs_rise & ~frame_ok;
    assign new_word  = sr[7:0];

    // Clear on frame start, shift one bit per synced spck rise.
    always_ff @(posedge pck0 or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            sr      <= '0;
        end else if (ncs_fall) begin
            bit_cnt <= '0;
            sr      <= '0;
        end else if (spck_rise && !ncs_s) begin
            sr      <= {sr[14:0], mosi_s};
            bit_cnt <= (bit_cnt == 5'd17) ? 5'd17 : bit_cnt + 5'd1;
        end
    end

    // Flag and count malformed frames; the counter saturates at 15.
    always_ff @(posedge pck0 or posedge reset) begin
        if (reset) begin
            cmd_err   <= 1'b0;
            err_count <= '0;
        end else begin
            cmd_err <= bad_frame;
            if (bad_frame && err_count != 4'hF) begin
                err_count <= err_count + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Glitch-free configuration apply FSM
    // ------------------------------------------------------------------
    state_t     state, state_next;
    logic [7:0] guard_cnt, guard_next;
    logic [7:0] apply_word, apply_next;
    logic       pend_valid, pend_valid_next;
    logic [7:0] pend_word, pend_word_next;
    logic [7:0] conf_next;
    logic       valid_next;
    logic       blank_next;
    logic [7:0] cand_word;

    // State register and registered FSM outputs.
    always_ff @(posedge pck0 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            guard_cnt  <= '0;
            apply_word <= '0;
            pend_valid <= 1'b0;
            pend_word  <= '0;
            conf_word  <= CONF_RESET;
            conf_valid <= 1'b0;
            mode_blank <= 1'b0;
        end else begin
            state      <= state_next;
            guard_cnt  <= guard_next;
            apply_word <= apply_next;
            pend_valid <= pend_valid_next;
            pend_word  <= pend_word_next;
            conf_word  <= conf_next;
            conf_valid <= valid_next;
            mode_blank <= blank_next;
        end
    end

    // Next-state logic: apply same-mode words at once, bracket mode changes.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_next      = state;
        guard_next      = guard_cnt;
        apply_next      = apply_word;
        pend_valid_next = pend_valid;
        pend_word_next  = pend_word;
        conf_next       = conf_word;
        valid_next      = 1'b0;
        cand_word       = accept ? new_word : pend_word;

        case (state)
            IDLE: begin
                if (accept || pend_valid) begin
                    pend_valid_next = 1'b0;
                    if (cand_word[7:5] == conf_word[7:5]) begin
                        conf_next  = cand_word;
                        valid_next = 1'b1;
                    end else begin
                        apply_next = cand_word;
                        guard_next = GUARD_LOAD;
                        state_next = BLANK_PRE;
                    end
                end
            end
            BLANK_PRE: begin
                // A newer word simply replaces the one about to be applied.
                if (accept) begin
                    apply_next = new_word;
                end
                if (guard_cnt == 8'd1) begin
                    conf_next  = accept ? new_word : apply_word;
                    guard_next = GUARD_LOAD;
                    state_next = BLANK_POST;
                end else begin
                    guard_next = guard_cnt - 8'd1;
                end
            end
            BLANK_POST: begin
                // Hold a newer word until the window closes.
                if (accept) begin
                    pend_valid_next = 1'b1;
                    pend_word_next  = new_word;
                end
                if (guard_cnt == 8'd1) begin
                    valid_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    guard_next = guard_cnt - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        blank_next = (state_next != IDLE);
    end

    // ------------------------------------------------------------------
    // Optional readback path
    // ------------------------------------------------------------------
`ifdef FPGA_SPI_CMD_READBACK_EN
    logic [15:0] readback;
    logic        spck_fall;

    assign spck_fall = ~spck_s & spck_d;

    // Load status at frame start, shift out on each synced spck fall.
    always_ff @(posedge pck0 or posedge reset) begin
        if (reset) begin
            readback <= '0;
        end else if (ncs_fall) begin
            readback <= {4'b0001, err_count, conf_word};
        end else if (spck_fall && !ncs_s) begin
            readback <= {readback[14:0], 1'b0};
        end
    end

    assign miso = ncs_s ? 1'b0 : readback[15];
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_spi_cmd.sv
// tb_fpga_spi_cmd: scoreboard bench for fpga_spi_cmd.
// Expected conf_word values and err_count values are queued when a frame is
// driven and popped by a monitor when conf_valid / cmd_err pulse.
// A long guard window is used so a whole frame fits inside BLANK_PRE.
// Readback checks follow FPGA_SPI_CMD_READBACK_EN.
module tb_fpga_spi_cmd;

    localparam int SYNC = 2;
    localparam int G    = 128;
    localparam int HALF = SYNC + 1;

    logic       pck0;
    logic       reset;
    logic       spck;
    logic       ncs;
    logic       mosi;
    logic       miso;
    logic [7:0] conf_word;
    logic       conf_valid;
    logic       mode_blank;
    logic       cmd_err;
    logic [3:0] err_count;

    fpga_spi_cmd #(
        .SYNC_STAGES (SYNC),
        .GUARD_CYCLES(G)
    ) dut (
        .pck0      (pck0),
        .reset     (reset),
        .spck      (spck),
        .ncs       (ncs),
        .mosi      (mosi),
        .miso      (miso),
        .conf_word (conf_word),
        .conf_valid(conf_valid),
        .mode_blank(mode_blank),
        .cmd_err   (cmd_err),
        .err_count (err_count)
    );

    initial pck0 = 1'b0;
    always #5 pck0 = ~pck0;

    int cyc = 0;
    always @(posedge pck0) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard queues and monitor marks
    logic [7:0] q_conf[$];
    logic [3:0] q_err[$];
    int         valid_cyc, err_cyc, blank_first, blank_last, blank_windows;
    int         word_change_cyc, n_valid, n_err;
    logic [7:0] word_change_val;
    logic       prev_blank = 1'b0;
    logic [7:0] prev_conf  = 8'hE0;

    task automatic clear_marks();
        valid_cyc       = -1;
        err_cyc         = -1;
        blank_first     = -1;
        blank_last      = -1;
        blank_windows   = 0;
        word_change_cyc = -1;
        word_change_val = 8'h00;
    endtask

    // Monitor: pop the scoreboard on output pulses, record event timing.
    always @(negedge pck0) begin
        if (!reset) begin
            if (conf_valid) begin
                valid_cyc = cyc;
                n_valid++;
                if (q_conf.size() == 0) check("conf_valid_spurious", q_conf.size(), 1);
                else                    check("conf_word_at_valid", conf_word, q_conf.pop_front());
            end
            if (cmd_err) begin
                err_cyc = cyc;
                n_err++;
                if (q_err.size() == 0) check("cmd_err_spurious", q_err.size(), 1);
                else                   check("err_count_at_cmd_err", err_count, q_err.pop_front());
            end
            if (mode_blank && !prev_blank) begin
                blank_first = cyc;
                blank_windows++;
            end
            if (!mode_blank && prev_blank) blank_last = cyc - 1;
            if (conf_word != prev_conf) begin
                word_change_cyc = cyc;
                word_change_val = conf_word;
            end
        end
        prev_blank = mode_blank;
        prev_conf  = conf_word;
    end

    // Drive one frame MSB first; returns the MISO stream and the cycle at
    // which ncs was raised.
    task automatic spi_frame(input logic [31:0] bits, input int n,
                             output logic [15:0] rd, output int raise_cyc);
        rd = '0;
        @(negedge pck0);
        ncs = 1'b0;
        repeat (HALF) @(negedge pck0);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            repeat (HALF) @(negedge pck0);
            spck = 1'b1;
            repeat (HALF) @(negedge pck0);
            rd   = {rd[14:0], miso};
            spck = 1'b0;
        end
        repeat (HALF) @(negedge pck0);
        ncs       = 1'b1;
        raise_cyc = cyc;
        repeat (3) @(negedge pck0);
    endtask

    // Wait (bounded) until blanking has ended and the scoreboard is drained.
    task automatic settle();
        int k;
        repeat (2) @(negedge pck0);
        k = 0;
        while ((mode_blank || q_conf.size() != 0 || q_err.size() != 0) && k < 4 * G) begin
            @(negedge pck0);
            k++;
        end
        check("settle", {31'b0, mode_blank} + q_conf.size() + q_err.size(), 0);
    endtask

    logic [7:0] m_conf;
    logic [3:0] m_err;

    function automatic logic [15:0] exp_rb(input logic [7:0] c, input logic [3:0] e);
`ifdef FPGA_SPI_CMD_READBACK_EN
        return {4'b0001, e, c};
`else
        return 16'h0000;
`endif
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [15:0] rb_exp;
        int          rc, rc1, rc2, nv, ne;

        reset = 1'b1; spck = 1'b0; ncs = 1'b1; mosi = 1'b0;
        n_valid = 0; n_err = 0;
        clear_marks();
        repeat (3) @(negedge pck0);
        reset = 1'b0;
        @(negedge pck0);

        // Reset state
        check("rst_conf_word", conf_word, 8'hE0);
        check("rst_mode_blank", mode_blank, 0);
        check("rst_err_count", err_count, 0);
        check("rst_conf_valid", conf_valid, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_miso", miso, 0);
        m_conf = 8'hE0; m_err = 4'd0;

        // Mode change E0 -> 23: blank window of 2G, word applied at mid-point
        clear_marks();
        rb_exp = exp_rb(m_conf, m_err);
        q_conf.push_back(8'h23);
        spi_frame(32'h1023, 16, rd, rc);
        check("t1_readback", rd, rb_exp);
        settle();
        m_conf = 8'h23;
        check("t1_blank_first", blank_first, rc + 3);
        check("t1_blank_last", blank_last, rc + 2 + 2 * G);
        check("t1_word_change", word_change_cyc, rc + 3 + G);
        check("t1_valid_cyc", valid_cyc, rc + 3 + 2 * G);
        check("t1_blank_windows", blank_windows, 1);
        check("t1_conf_word", conf_word, 8'h23);

        // Same mode 23 -> 21: immediate, no blanking
        clear_marks();
        q_conf.push_back(8'h21);
        spi_frame(32'h1021, 16, rd, rc);
        settle();
        m_conf = 8'h21;
        check("t2_valid_cyc", valid_cyc, rc + 3);
        check("t2_word_change", word_change_cyc, rc + 3);
        check("t2_blank_windows", blank_windows, 0);
        check("t2_conf_word", conf_word, 8'h21);
        check("t2_miso_idle", miso, 0);

        // 15-bit then 17-bit frames: two errors, config untouched
        clear_marks();
        q_err.push_back(4'd1);
        spi_frame(32'h1023, 15, rd, rc);
        settle();
        check("t3_err_cyc_15", err_cyc, rc + 3);
        q_err.push_back(4'd2);
        spi_frame(32'h1_0023, 17, rd, rc);
        settle();
        m_err = 4'd2;
        check("t3_err_cyc_17", err_cyc, rc + 3);
        check("t3_err_count", err_count, 2);
        check("t3_conf_word", conf_word, 8'h21);
        check("t3_no_valid", valid_cyc, -1);

        // Reserved opcode: no change, no error; readback shows 1221
        clear_marks();
        nv = n_valid; ne = n_err;
        rb_exp = exp_rb(m_conf, m_err);
        spi_frame(32'h2055, 16, rd, rc);
        settle();
        repeat (4) @(negedge pck0);
        check("t4_readback", rd, rb_exp);
        check("t4_conf_word", conf_word, 8'h21);
        check("t4_err_count", err_count, 2);
        check("t4_valid_count", n_valid, nv);
        check("t4_err_pulses", n_err, ne);

        // 20 one-bit frames: counter saturates at 15, pulse every time
        for (int i = 0; i < 20; i++) begin
            m_err = (m_err == 4'hF) ? 4'hF : m_err + 4'd1;
            q_err.push_back(m_err);
            spi_frame(32'h1, 1, rd, rc);
            settle();
        end
        check("t5_err_count", err_count, 15);
        check("t5_conf_word", conf_word, 8'h21);

        // Two words during BLANK_PRE: the newer one wins, one window only
        clear_marks();
        q_conf.push_back(8'h60);
        spi_frame(32'h1040, 16, rd, rc1);
        rb_exp = exp_rb(m_conf, m_err);
        spi_frame(32'h1060, 16, rd, rc2);
        check("t6_old_word_held", conf_word, 8'h21);
        check("t6_in_blank", mode_blank, 1);
        check("t6_readback", rd, rb_exp);
        settle();
        m_conf = 8'h60;
        check("t6_word_change", word_change_cyc, rc1 + 3 + G);
        check("t6_word_change_val", word_change_val, 8'h60);
        check("t6_valid_cyc", valid_cyc, rc1 + 3 + 2 * G);
        check("t6_blank_windows", blank_windows, 1);
        check("t6_conf_word", conf_word, 8'h60);

        // Reset after 8 bits of 1080: reset values, then a clean frame
        @(negedge pck0);
        ncs = 1'b0;
        repeat (HALF) @(negedge pck0);
        for (int i = 15; i >= 8; i--) begin
            mosi = (i == 12);
            repeat (HALF) @(negedge pck0);
            spck = 1'b1;
            repeat (HALF) @(negedge pck0);
            spck = 1'b0;
        end
        reset = 1'b1; ncs = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge pck0);
        check("t7_rst_conf_word", conf_word, 8'hE0);
        check("t7_rst_err_count", err_count, 0);
        check("t7_rst_mode_blank", mode_blank, 0);
        reset = 1'b0;
        m_conf = 8'hE0; m_err = 4'd0;
        clear_marks();
        ne = n_err;
        repeat (6) @(negedge pck0);
        check("t7_no_err_after_rst", n_err, ne);
        rb_exp = exp_rb(m_conf, m_err);
        q_conf.push_back(8'h80);
        spi_frame(32'h1080, 16, rd, rc);
        settle();
        check("t7_readback", rd, rb_exp);
        check("t7_conf_word", conf_word, 8'h80);
        check("t7_err_count", err_count, 0);
        check("t7_blank_windows", blank_windows, 1);
        check("t7_valid_cyc", valid_cyc, rc + 3 + 2 * G);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
